// File: rtl/spi_apb_top.sv
// rtl/spi_apb_top.sv - SPI master with an 8-bit APB register map (CR1/CR2/BR/SR/DR).
// One byte per transfer; mode, bit order and divisor are captured when each transfer starts.
module spi_apb_top (
    input  logic       PCLK,
    input  logic       PRESETn,
    input  logic [2:0] PADDR,
    input  logic       PWRITE,
    input  logic       PSEL,
    input  logic       PENABLE,
    input  logic [7:0] PWDATA,
    input  logic       miso,
    output logic       ss,
    output logic       sclk,
    output logic       spi_interrupt_request,
    output logic       mosi,
    output logic [7:0] PRDATA,
    output logic       PREADY,
    output logic       PSLVERR
);
    typedef enum logic {IDLE, XFER} state_t;

    state_t      state_q;
    logic [7:0]  cr1_q, cr2_q, br_q, tx_buf_q, rx_buf_q, shift_q;
    logic        spif_q, sptef_q, sr_seen_q;
    logic        cpha_q, lsbfe_q;
    logic [10:0] half_q, cnt_q;
    logic [4:0]  edge_q;
    logic        ss_q, sclk_q, mosi_q, irq_q;

    logic        wr_en, rd_en, sample_edge, out_bit;
    logic [4:0]  edge_d;
    logic [7:0]  shift_d, sr_val;
    logic [10:0] half_d;

    assign wr_en       = PSEL & PENABLE & PWRITE;
    assign rd_en       = PSEL & PENABLE & ~PWRITE;
    assign edge_d      = edge_q + 5'd1;
    // Edge numbers start at 1: cpha=0 samples on odd edges, cpha=1 on even ones.
    assign sample_edge = edge_d[0] ^ cpha_q;
    assign shift_d     = lsbfe_q ? {miso, shift_q[7:1]} : {shift_q[6:0], miso};
    assign out_bit     = lsbfe_q ? shift_q[0] : shift_q[7];
    assign half_d      = {7'd0, ({1'b0, br_q[6:4]} + 4'd1)} << br_q[2:0];
    assign sr_val      = {spif_q, 1'b0, sptef_q, 1'b0, 4'b0000};

    always_comb begin
        PRDATA = 8'h00;
        if (PSEL && !PWRITE) begin
            case (PADDR)
                3'd0:    PRDATA = cr1_q;
                3'd1:    PRDATA = cr2_q;
                3'd2:    PRDATA = br_q;
                3'd3:    PRDATA = sr_val;
                3'd5:    PRDATA = rx_buf_q;
                default: PRDATA = 8'h00;
            endcase
        end
    end

    assign PSLVERR = PSEL & PENABLE & ((PADDR == 3'd4) | (PADDR == 3'd6) | (PADDR == 3'd7));
    assign PREADY  = 1'b1;
    assign ss      = ss_q;
    assign sclk    = sclk_q;
    assign mosi    = mosi_q;
    assign spi_interrupt_request = irq_q;

    always_ff @(posedge PCLK) begin
        if (PRESETn) begin
            state_q   <= IDLE;
            cr1_q     <= 8'h04;
            cr2_q     <= 8'h00;
            br_q      <= 8'h00;
            tx_buf_q  <= 8'h00;
            rx_buf_q  <= 8'h00;
            shift_q   <= 8'h00;
            spif_q    <= 1'b0;
            sptef_q   <= 1'b1;
            sr_seen_q <= 1'b0;
            cpha_q    <= 1'b0;
            lsbfe_q   <= 1'b0;
            half_q    <= 11'd1;
            cnt_q     <= 11'd0;
            edge_q    <= 5'd0;
            ss_q      <= 1'b1;
            sclk_q    <= 1'b0;
            mosi_q    <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            irq_q <= (cr1_q[7] & spif_q) | (cr1_q[5] & sptef_q);
            if (wr_en) begin
                case (PADDR)
                    3'd0: cr1_q <= PWDATA;
                    3'd1: cr2_q <= PWDATA & 8'h1B;
                    3'd2: br_q  <= PWDATA & 8'h77;
                    3'd5: if (sptef_q) begin
                        tx_buf_q <= PWDATA;
                        sptef_q  <= 1'b0;
                    end
                    default: ;
                endcase
            end
            // spif clears only on an SR read (with spif set) followed by a DR read.
            if (rd_en && PADDR == 3'd3 && spif_q)
                sr_seen_q <= 1'b1;
            if (rd_en && PADDR == 3'd5 && sr_seen_q) begin
                spif_q    <= 1'b0;
                sr_seen_q <= 1'b0;
            end
            case (state_q)
                IDLE: begin
                    sclk_q <= cr1_q[3];
                    if (!sptef_q && cr1_q[6] && cr1_q[4]) begin
                        state_q <= XFER;
                        shift_q <= tx_buf_q;
                        sptef_q <= 1'b1;
                        ss_q    <= 1'b0;
                        cpha_q  <= cr1_q[2];
                        lsbfe_q <= cr1_q[0];
                        half_q  <= half_d;
                        cnt_q   <= 11'd0;
                        edge_q  <= 5'd0;
                        mosi_q  <= cr1_q[0] ? tx_buf_q[0] : tx_buf_q[7];
                    end
                end
                XFER: begin
                    if (!cr1_q[6]) begin
                        state_q <= IDLE;
                        ss_q    <= 1'b1;
                        sclk_q  <= cr1_q[3];
                    end else if (cnt_q != half_q - 11'd1) begin
                        cnt_q <= cnt_q + 11'd1;
                    end else begin
                        cnt_q <= 11'd0;
                        if (edge_q == 5'd16) begin
                            rx_buf_q <= shift_q;
                            spif_q   <= 1'b1;
                            ss_q     <= 1'b1;
                            state_q  <= IDLE;
                        end else begin
                            edge_q <= edge_d;
                            sclk_q <= ~sclk_q;
                            if (sample_edge)
                                shift_q <= shift_d;
                            else if (edge_q != 5'd15)
                                mosi_q <= out_bit;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_spi_apb_top.sv
// tb/tb_spi_apb_top.sv - scoreboard bench for spi_apb_top: APB read and SPI byte monitors.
module tb_spi_apb_top;
    logic       PCLK = 1'b0;
    logic       PRESETn = 1'b1;
    logic [2:0] PADDR = 3'd0;
    logic       PWRITE = 1'b0;
    logic       PSEL = 1'b0;
    logic       PENABLE = 1'b0;
    logic [7:0] PWDATA = 8'h00;
    logic       miso = 1'b0;
    logic       ss, sclk, spi_interrupt_request, mosi, PREADY, PSLVERR;
    logic [7:0] PRDATA;

    spi_apb_top dut (
        .PCLK(PCLK), .PRESETn(PRESETn), .PADDR(PADDR), .PWRITE(PWRITE),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWDATA(PWDATA), .miso(miso),
        .ss(ss), .sclk(sclk), .spi_interrupt_request(spi_interrupt_request),
        .mosi(mosi), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    always #5 PCLK = ~PCLK;

    typedef struct {
        logic [2:0] addr;
        logic [7:0] data;
        logic       err;
    } rd_exp_t;

    typedef struct {
        logic [7:0] data;
        logic       lsb;
        logic       full;
        int         d;
    } spi_exp_t;

    rd_exp_t  rd_q[$];
    spi_exp_t sp_q[$];
    int n_chk = 0;
    int n_fail = 0;
    int xfer_cnt = 0;
    logic [7:0] slave_data = 8'h00;
    int bit_idx = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic apb_write(input logic [2:0] a, input logic [7:0] d);
        @(posedge PCLK); #1;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = a; PWDATA = d;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        @(posedge PCLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    endtask

    task automatic apb_read(input logic [2:0] a, input logic [7:0] exp, input logic err);
        rd_exp_t e;
        e.addr = a; e.data = exp; e.err = err;
        rd_q.push_back(e);
        @(posedge PCLK); #1;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = a;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        @(posedge PCLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0;
    endtask

    task automatic expect_spi(input logic [7:0] d, input logic lsb, input logic full, input int div);
        spi_exp_t e;
        e.data = d; e.lsb = lsb; e.full = full; e.d = div;
        sp_q.push_back(e);
    endtask

    task automatic wait_xfers(input int target);
        int t = 0;
        while (xfer_cnt < target && t < 5000) begin
            @(posedge PCLK);
            t++;
        end
        check("xfer_done_in_time", 32'(xfer_cnt >= target), 32'd1);
    endtask

    // APB read monitor: compares data and error in the access phase.
    initial begin
        rd_exp_t e;
        forever begin
            @(negedge PCLK);
            if (PSEL && PENABLE && !PWRITE) begin
                if (rd_q.size() == 0) begin
                    check("rd_unexpected", 32'd1, 32'd0);
                end else begin
                    e = rd_q.pop_front();
                    check($sformatf("prdata_a%0d", e.addr), 32'(PRDATA), 32'(e.data));
                    check($sformatf("pslverr_a%0d", e.addr), 32'(PSLVERR), 32'(e.err));
                end
            end
        end
    end

    // SPI monitor: mosi captured on rising sclk while ss is low.
    initial begin
        spi_exp_t e;
        int bits, cyc;
        logic [7:0] lsb_val, msb_val;
        logic prev;
        forever begin
            @(negedge ss);
            bits = 0; cyc = 0; lsb_val = 8'h00; msb_val = 8'h00; prev = sclk;
            forever begin
                @(negedge PCLK);
                if (ss || cyc > 20000) break;
                cyc++;
                if (sclk && !prev) begin
                    if (bits < 8) begin
                        lsb_val[bits] = mosi;
                        msb_val[7 - bits] = mosi;
                    end
                    bits++;
                end
                prev = sclk;
            end
            if (sp_q.size() == 0) begin
                check("spi_unexpected", 32'd1, 32'd0);
            end else begin
                e = sp_q.pop_front();
                if (e.full) begin
                    check("spi_bits", 32'(bits), 32'd8);
                    check("spi_mosi_byte", 32'(e.lsb ? lsb_val : msb_val), 32'(e.data));
                    check("ss_low_len", 32'((cyc >= 8 * e.d) && (cyc <= 8 * e.d + e.d / 2 + 2)), 32'd1);
                end else begin
                    check("spi_abort_short", 32'(bits < 8), 32'd1);
                end
            end
            xfer_cnt++;
        end
    end

    // Mode-0 slave: first bit before the first edge, next bit on each falling sclk.
    initial begin
        forever begin
            @(negedge ss);
            bit_idx = 7;
            miso = slave_data[7];
        end
    end
    initial begin
        forever begin
            @(negedge sclk);
            if (ss === 1'b0 && bit_idx > 0) begin
                bit_idx--;
                miso = slave_data[bit_idx];
            end
        end
    end

    initial begin
        repeat (3) @(posedge PCLK);
        @(negedge PCLK);
        check("rst_ss", 32'(ss), 32'd1);
        check("rst_sclk", 32'(sclk), 32'd0);
        check("rst_mosi", 32'(mosi), 32'd0);
        check("rst_irq", 32'(spi_interrupt_request), 32'd0);
        check("rst_prdata", 32'(PRDATA), 32'd0);
        check("rst_pslverr", 32'(PSLVERR), 32'd0);
        check("rst_pready", 32'(PREADY), 32'd1);
        PRESETn = 1'b0;

        // Register reset values and unmapped address.
        apb_read(3'd0, 8'h04, 1'b0);
        apb_read(3'd1, 8'h00, 1'b0);
        apb_read(3'd2, 8'h00, 1'b0);
        apb_read(3'd3, 8'h20, 1'b0);
        apb_read(3'd5, 8'h00, 1'b0);
        apb_read(3'd6, 8'h00, 1'b1);

        // Mode 0, LSB first, D=192.
        apb_write(3'd2, 8'h25);
        apb_write(3'd0, 8'hD1);
        @(negedge PCLK);
        check("t2_sclk_idle", 32'(sclk), 32'd0);
        expect_spi(8'hAA, 1'b1, 1'b1, 192);
        apb_write(3'd5, 8'hAA);
        wait_xfers(1);
        @(negedge PCLK);
        check("t2_sclk_idle_after", 32'(sclk), 32'd0);

        // Mode 0, MSB first, slave returns 0x3C.
        slave_data = 8'h3C;
        apb_write(3'd0, 8'hD0);
        expect_spi(8'h81, 1'b0, 1'b1, 192);
        apb_write(3'd5, 8'h81);
        wait_xfers(2);
        apb_read(3'd3, 8'hA0, 1'b0);
        check("t3_irq_set", 32'(spi_interrupt_request), 32'd1);
        apb_read(3'd5, 8'h3C, 1'b0);
        apb_read(3'd3, 8'h20, 1'b0);
        repeat (2) @(negedge PCLK);
        check("t3_irq_clear", 32'(spi_interrupt_request), 32'd0);
        slave_data = 8'h00;

        // Mode 3, MSB first, D=4.
        apb_write(3'd2, 8'h01);
        apb_write(3'd0, 8'hDC);
        repeat (2) @(negedge PCLK);
        check("t4_sclk_idle_hi", 32'(sclk), 32'd1);
        expect_spi(8'hF0, 1'b0, 1'b1, 4);
        apb_write(3'd5, 8'hF0);
        wait_xfers(3);
        @(negedge PCLK);
        check("t4_sclk_idle_after", 32'(sclk), 32'd1);
        apb_read(3'd3, 8'hA0, 1'b0);
        apb_read(3'd5, 8'h00, 1'b0);
        apb_read(3'd3, 8'h20, 1'b0);

        // Back-to-back transfers; third write finds sptef=0 and is dropped.
        apb_write(3'd2, 8'h10);
        apb_write(3'd0, 8'hD1);
        expect_spi(8'h12, 1'b1, 1'b1, 4);
        expect_spi(8'h34, 1'b1, 1'b1, 4);
        apb_write(3'd5, 8'h12);
        apb_write(3'd5, 8'h34);
        apb_write(3'd5, 8'h56);
        wait_xfers(5);
        repeat (100) @(posedge PCLK);
        @(negedge PCLK);
        check("t5_no_third_xfer", 32'(xfer_cnt), 32'd5);
        check("t5_ss_idle", 32'(ss), 32'd1);
        apb_read(3'd3, 8'hA0, 1'b0);
        apb_read(3'd5, 8'h00, 1'b0);
        apb_read(3'd3, 8'h20, 1'b0);

        // Abort by clearing spe mid-transfer.
        apb_write(3'd2, 8'h25);
        expect_spi(8'h77, 1'b1, 1'b0, 192);
        apb_write(3'd5, 8'h77);
        repeat (300) @(posedge PCLK);
        @(negedge PCLK);
        check("t6_ss_low_mid", 32'(ss), 32'd0);
        apb_write(3'd0, 8'h91);
        @(posedge PCLK);
        @(negedge PCLK);
        check("t6_abort_ss", 32'(ss), 32'd1);
        check("t6_abort_sclk", 32'(sclk), 32'd0);
        apb_read(3'd3, 8'h20, 1'b0);

        // Reset mid-transfer.
        apb_write(3'd0, 8'hD1);
        expect_spi(8'h99, 1'b1, 1'b0, 192);
        apb_write(3'd5, 8'h99);
        repeat (300) @(posedge PCLK);
        @(negedge PCLK);
        check("t6_ss_low_before_rst", 32'(ss), 32'd0);
        PRESETn = 1'b1;
        @(posedge PCLK);
        @(negedge PCLK);
        check("t6_rst_ss", 32'(ss), 32'd1);
        check("t6_rst_sclk", 32'(sclk), 32'd0);
        check("t6_rst_mosi", 32'(mosi), 32'd0);
        check("t6_rst_irq", 32'(spi_interrupt_request), 32'd0);
        check("t6_rst_prdata", 32'(PRDATA), 32'd0);
        check("t6_rst_pslverr", 32'(PSLVERR), 32'd0);
        PRESETn = 1'b0;
        apb_read(3'd0, 8'h04, 1'b0);
        apb_read(3'd3, 8'h20, 1'b0);
        repeat (4) @(posedge PCLK);
        check("rd_queue_drained", 32'(rd_q.size()), 32'd0);
        check("spi_queue_drained", 32'(sp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
